period_meter: RTL and testbench

//  Measures, in clk cycles, the period of an external digital signal.

---
 rtl/period_meter.sv | 187 ++++++++++++++++++
 tb/tb_period_meter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
`default_nettype none
//============================================================================
// Module   : period_meter
// Purpose  : Measures the rising-to-rising period of an external digital
//            signal in clk cycles. A start pulse arms the block; the first
//            synchronized rise of sig_in starts the count and the next one
//            ends it. The result is presented with a done/ack handshake.
//            The counter saturates at 2^N-1. If no second rise arrives by
//            then, the result is 2^N-1 and overflow is raised.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters
//   N          width of the period counter and of the result (default 16)
// Ports
//   clk        in   1  system clock, rising edge
//   reset      in   1  synchronous, active-low reset
//   start      in   1  arm request (IDLE, or DONE together with ack)
//   sig_in     in   1  asynchronous signal under measurement
//   ack        in   1  consumer acknowledge, meaningful in DONE only
//   busy       out  1  high in ARM or MEASURE
//   done       out  1  result valid, held until ack
//   period     out  N  measured interval in clk cycles
//   high_time  out  N  rise-to-fall time, only with PERIOD_METER_HIGH_TIME_EN
//   overflow   out  1  no second rise before the counter saturated
// Configuration
//   PERIOD_METER_HIGH_TIME_EN  when defined, adds the high_time output and
//                              the counter behind it
//============================================================================
module period_meter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         sig_in,
  input  logic         ack,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] period,
`ifdef PERIOD_METER_HIGH_TIME_EN
  output logic [N-1:0] high_time,
`endif
  output logic         overflow
);

  localparam logic [N-1:0] c_cnt_max = {N{1'b1}};
  localparam logic [N-1:0] c_one     = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t       r_state;

  // s1/s2 form the synchronizer. s3 delays s2 by one cycle for edge
  // detection. The pin-to-edge latency is constant, so it cancels out of
  // every measured interval.
  logic         r_s1;
  logic         r_s2;
  logic         r_s3;
  logic [N-1:0] r_cnt;
  logic         w_rise;

  assign w_rise = r_s2 & ~r_s3;

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [N-1:0] r_hcnt;
  logic         r_fall_seen;
  logic         w_fall;

  assign w_fall = ~r_s2 & r_s3;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_cnt       <= '0;
      period      <= '0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef PERIOD_METER_HIGH_TIME_EN
      r_hcnt      <= '0;
      r_fall_seen <= 1'b0;
      high_time   <= '0;
`endif
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      case (r_state)
        ST_IDLE: begin
          // A rise coinciding with start is ignored: ARM only looks for
          // edges from the next cycle on.
          if (start) begin
            r_state <= ST_ARM;
            busy    <= 1'b1;
          end
        end

        ST_ARM: begin
          // The cycle in which the first rise is seen counts as 1, so the
          // count at the next rise equals the edge-to-edge distance.
          if (w_rise) begin
            r_state     <= ST_MEASURE;
            r_cnt       <= c_one;
`ifdef PERIOD_METER_HIGH_TIME_EN
            r_hcnt      <= c_one;
            r_fall_seen <= 1'b0;
`endif
          end
        end

        ST_MEASURE: begin
`ifdef PERIOD_METER_HIGH_TIME_EN
          // The high-time counter runs alongside r_cnt until the first fall
          // and then freezes. It saturates the same way as r_cnt.
          if (w_fall && !r_fall_seen) begin
            high_time   <= r_hcnt;
            r_fall_seen <= 1'b1;
          end else if (!r_fall_seen && (r_hcnt != c_cnt_max)) begin
            r_hcnt <= r_hcnt + c_one;
          end
`endif
          if (w_rise) begin
            period   <= r_cnt;
            overflow <= 1'b0;
            r_state  <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
`ifdef PERIOD_METER_HIGH_TIME_EN
            // Rise and fall are never seen together, so no fall is pending
            // here. Without a fall, the high time spans the whole period.
            if (!r_fall_seen) begin
              high_time <= r_hcnt;
            end
`endif
          end else if (r_cnt == c_cnt_max) begin
            period   <= c_cnt_max;
            overflow <= 1'b1;
            r_state  <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
`ifdef PERIOD_METER_HIGH_TIME_EN
            // If a fall arrives in this same cycle, the fall branch above
            // writes the same r_hcnt value, so the two writes agree.
            if (!r_fall_seen) begin
              high_time <= r_hcnt;
            end
`endif
          end else begin
            r_cnt <= r_cnt + c_one;
          end
        end

        ST_DONE: begin
          // Results stay frozen until ack. A start without ack is dropped.
          // ack together with start re-arms without passing through IDLE.
          if (ack) begin
            done <= 1'b0;
            if (start) begin
              r_state <= ST_ARM;
              busy    <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
//============================================================================
// Module   : tb_period_meter
// Purpose  : Directed self-checking bench for period_meter. The main
//            instance (N=16) covers period, handshake and reset behaviour.
//            A second instance (N=8) covers counter saturation. Expected
//            results are queued when the stimulus is generated and are
//            compared when done rises.
// Revision : 1.0 - initial release
//============================================================================
module tb_period_meter;

  typedef struct {
    logic [15:0] period;
    logic        ovf;
    logic [15:0] high;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        sig_in = 1'b0;
  logic        ack = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] period;
  logic        overflow;

  logic        start8 = 1'b0;
  logic        sig8 = 1'b0;
  logic        ack8 = 1'b0;
  logic        busy8;
  logic        done8;
  logic [7:0]  period8;
  logic        overflow8;

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [15:0] high_time;
  logic [7:0]  high_time8;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  period_meter #(.N(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sig_in   (sig_in),
    .ack      (ack),
    .busy     (busy),
    .done     (done),
    .period   (period),
`ifdef PERIOD_METER_HIGH_TIME_EN
    .high_time(high_time),
`endif
    .overflow (overflow)
  );

  period_meter #(.N(8)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .start    (start8),
    .sig_in   (sig8),
    .ack      (ack8),
    .busy     (busy8),
    .done     (done8),
    .period   (period8),
`ifdef PERIOD_METER_HIGH_TIME_EN
    .high_time(high_time8),
`endif
    .overflow (overflow8)
  );

  // All driving and sampling happens on the falling edge, away from the
  // active clock edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // Produces two pin rises p cycles apart. The first high phase lasts h
  // cycles. The expected result is queued as the stimulus is produced.
  task automatic gen(input int p, input int h);
    exp_t e;
    e.period = 16'(p);
    e.ovf    = 1'b0;
    e.high   = 16'(h);
    sb.push_back(e);
    sig_in = 1'b1;
    repeat (h) tick();
    sig_in = 1'b0;
    repeat (p - h) tick();
    sig_in = 1'b1;
    repeat (h) tick();
    sig_in = 1'b0;
    tick();
  endtask

  // Waits a bounded time for done, then pops the scoreboard and compares.
  task automatic wait_result(input string tag);
    exp_t e;
    for (int i = 0; i < 400 && done !== 1'b1; i++) tick();
    chk({tag, "_done"}, done, 1'b1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_period"}, period, e.period);
      chk({tag, "_overflow"}, overflow, e.ovf);
      chk({tag, "_busy"}, busy, 1'b0);
`ifdef PERIOD_METER_HIGH_TIME_EN
      chk({tag, "_high_time"}, high_time, e.high);
`endif
    end
  endtask

  initial begin
    // Reset
    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_period", period, 16'd0);
    chk("rst_overflow", overflow, 1'b0);
    reset = 1'b1;
    tick();

    // Rises 100 cycles apart, high for 30 cycles
    pulse_start();
    chk("arm_busy", busy, 1'b1);
    tick();
    gen(100, 30);
    wait_result("p100");

    // In DONE, start without ack is ignored
    pulse_start();
    tick();
    chk("start_only_done", done, 1'b1);
    chk("start_only_period", period, 16'd100);

    // ack and start together re-arm directly
    ack   = 1'b1;
    start = 1'b1;
    tick();
    ack   = 1'b0;
    start = 1'b0;
    chk("rearm_busy", busy, 1'b1);
    chk("rearm_done", done, 1'b0);
    tick();
    gen(50, 20);
    wait_result("p50");
    pulse_ack();
    chk("ack_done", done, 1'b0);
    chk("ack_busy", busy, 1'b0);

    // Minimum period: the pin toggles every clk
    tick();
    pulse_start();
    tick();
    gen(2, 1);
    wait_result("p2");
    pulse_ack();

    // Reset while measuring discards the measurement
    pulse_start();
    tick();
    sig_in = 1'b1;
    repeat (43) tick();
    chk("mid_busy", busy, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mreset_busy", busy, 1'b0);
    chk("mreset_done", done, 1'b0);
    chk("mreset_period", period, 16'd0);
    chk("mreset_overflow", overflow, 1'b0);
    sig_in = 1'b0;
    repeat (5) tick();
    sig_in = 1'b1;
    repeat (10) tick();
    chk("noarm_busy", busy, 1'b0);
    chk("noarm_done", done, 1'b0);
    sig_in = 1'b0;

    // N=8 saturation: one rise, then the pin is held high
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    sig8 = 1'b1;
    repeat (257) tick();
    chk("sat_done_early", done8, 1'b0);
    chk("sat_busy_early", busy8, 1'b1);
    tick();
    chk("sat_done", done8, 1'b1);
    chk("sat_period", period8, 8'd255);
    chk("sat_overflow", overflow8, 1'b1);
    chk("sat_busy", busy8, 1'b0);
`ifdef PERIOD_METER_HIGH_TIME_EN
    chk("sat_high_time", high_time8, 8'd255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
